// File: rtl/frontend_sw_pkg.sv
// Shared definitions for the RX frontend-to-DSP channel switch sequencer.
package frontend_sw_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitIdle = 2'd1,
        StSwitch   = 2'd2,
        StSettle   = 2'd3
    } fsw_state_e;

    // Settings register offsets relative to BASE
    localparam logic [7:0] REQ_OFS  = 8'd0;
    localparam logic [7:0] TIME_OFS = 8'd1;

    // Field positions inside the settings data word
    localparam int unsigned FORCE_BIT  = 31;
    localparam int unsigned TMO_LSB    = 16;
    localparam int unsigned SETTLE_MSB = 15;

endpackage

// File: rtl/fsw_downcnt.sv
// 16-bit loadable down-counter; holds at zero and flags it.
module fsw_downcnt
    import frontend_sw_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic        zero
);

    logic [15:0] count_q;

    // Load has priority over decrement; decrement stops at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 16'd0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != 16'd0)) begin
            count_q <= count_q - 16'd1;
        end
    end

    assign zero = (count_q == 16'd0);

endmodule

// File: rtl/frontend_sw_ctrl.sv
// Frontend switch sequencer: waits for affected DSP channels to go idle (or a
// timeout), applies the new ADC mapping and blanks changed channels while the
// frontend settles. Optional statistics counters via FRONTEND_SW_STATS_EN.
module frontend_sw_ctrl
    import frontend_sw_pkg::*;
#(
    parameter logic [7:0]  BASE  = 8'd0,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] run_in,
    output logic [WIDTH-1:0] front_sw,
    output logic [WIDTH-1:0] blank,
    output logic             busy,
    output logic             timeout_flag
`ifdef FRONTEND_SW_STATS_EN
    ,
    output logic [15:0]      sw_count,
    output logic [15:0]      tmo_count
`endif
);

    localparam logic [7:0] ADDR_REQ  = BASE + REQ_OFS;
    localparam logic [7:0] ADDR_TIME = BASE + TIME_OFS;

    fsw_state_e       state_q;
    logic [WIDTH-1:0] req_q, chg_q;
    logic             force_q, pend_q, tmo_armed_q;
    logic [15:0]      settle_q, tmo_q;

    logic             base_wr, time_wr;
    logic [WIDTH-1:0] wr_req, wr_chg, idle_chg;
    logic             idle_start, wait_exit, timeout_hit;
    logic             tmo_load, tmo_dec, tmo_zero;
    logic             set_load, set_dec, set_zero;
    logic [15:0]      tmo_ld_val;

    // Decode settings writes and the FSM transition conditions
    always_comb begin
        base_wr    = set_stb && (set_addr == ADDR_REQ);
        time_wr    = set_stb && (set_addr == ADDR_TIME);
        wr_req     = set_data[WIDTH-1:0];
        wr_chg     = wr_req ^ front_sw;
        idle_chg   = req_q ^ front_sw;
        // A write in IDLE starts immediately; otherwise a latched request is used
        idle_start = (state_q == StIdle) &&
                     (base_wr ? (wr_chg != '0) : (pend_q && (idle_chg != '0)));
        // A concurrent request write keeps us waiting with the new mapping
        wait_exit  = (state_q == StWaitIdle) && !base_wr &&
                     (force_q || ((run_in & chg_q) == '0) || (tmo_armed_q && tmo_zero));
        timeout_hit = wait_exit && !force_q && ((run_in & chg_q) != '0);
        // Counter is loaded with tmo-1 so the wait lasts exactly tmo cycles
        tmo_ld_val = (tmo_q == 16'd0) ? 16'd0 : tmo_q - 16'd1;
        tmo_load   = idle_start || ((state_q == StWaitIdle) && base_wr);
        tmo_dec    = (state_q == StWaitIdle);
        set_load   = wait_exit;
        set_dec    = (state_q == StSwitch) || (state_q == StSettle);
    end

    fsw_downcnt u_tmo_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (tmo_load),
        .load_val (tmo_ld_val),
        .dec      (tmo_dec),
        .zero     (tmo_zero)
    );

    fsw_downcnt u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (set_load),
        .load_val (settle_q),
        .dec      (set_dec),
        .zero     (set_zero)
    );

    // Settings registers and the switch sequencing FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            req_q        <= '0;
            chg_q        <= '0;
            force_q      <= 1'b0;
            pend_q       <= 1'b0;
            tmo_armed_q  <= 1'b0;
            settle_q     <= 16'd0;
            tmo_q        <= 16'd0;
            front_sw     <= '0;
            blank        <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (base_wr) begin
                req_q        <= wr_req;
                force_q      <= set_data[FORCE_BIT];
                pend_q       <= 1'b1;
                timeout_flag <= 1'b0;
            end
            if (time_wr) begin
                settle_q <= set_data[SETTLE_MSB:0];
                tmo_q    <= set_data[31:TMO_LSB];
            end
            unique case (state_q)
                StIdle: begin
                    // Any request seen here is consumed, including no-ops
                    pend_q <= 1'b0;
                    if (idle_start) begin
                        state_q     <= StWaitIdle;
                        chg_q       <= base_wr ? wr_chg : idle_chg;
                        tmo_armed_q <= (tmo_q != 16'd0);
                    end
                end
                StWaitIdle: begin
                    if (base_wr) begin
                        pend_q      <= 1'b0;
                        chg_q       <= wr_chg;
                        tmo_armed_q <= (tmo_q != 16'd0);
                    end else if (wait_exit) begin
                        state_q  <= StSwitch;
                        front_sw <= req_q;
                        blank    <= chg_q;
                        if (timeout_hit) begin
                            timeout_flag <= 1'b1;
                        end
                    end
                end
                StSwitch: begin
                    if (set_zero) begin
                        state_q <= StIdle;
                        blank   <= '0;
                    end else begin
                        state_q <= StSettle;
                    end
                end
                StSettle: begin
                    if (set_zero) begin
                        state_q <= StIdle;
                        blank   <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);

`ifdef FRONTEND_SW_STATS_EN
    // Switch counter wraps; timeout counter saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_count  <= 16'd0;
            tmo_count <= 16'd0;
        end else begin
            if (state_q == StSwitch) begin
                sw_count <= sw_count + 16'd1;
            end
            if (timeout_hit && (tmo_count != 16'hFFFF)) begin
                tmo_count <= tmo_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frontend_sw_ctrl.sv
// Directed self-checking bench for frontend_sw_ctrl.
module tb_frontend_sw_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic [3:0]  run_in = 4'd0;
    logic [3:0]  front_sw, blank;
    logic        busy, timeout_flag;
`ifdef FRONTEND_SW_STATS_EN
    logic [15:0] sw_count, tmo_count;
`endif

    int checks = 0;
    int errors = 0;

    frontend_sw_ctrl #(.BASE(8'd0), .WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .set_stb      (set_stb),
        .set_addr     (set_addr),
        .set_data     (set_data),
        .run_in       (run_in),
        .front_sw     (front_sw),
        .blank        (blank),
        .busy         (busy),
        .timeout_flag (timeout_flag)
`ifdef FRONTEND_SW_STATS_EN
        ,
        .sw_count     (sw_count),
        .tmo_count    (tmo_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write is sampled on the next posedge (E0); returns at E0+1
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        @(posedge clk);
        #1;
        set_stb = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        do_reset();
        chk("rst_front_sw", {28'd0, front_sw}, 32'h0);
        chk("rst_blank", {28'd0, blank}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_tmo_flag", {31'd0, timeout_flag}, 32'h0);

        // Idle channels, settle=0
        wr(8'd1, 32'h0000_0000);
        wr(8'd0, 32'h0000_0005);
        chk("t1_e0_busy", {31'd0, busy}, 32'h1);
        chk("t1_e0_front", {28'd0, front_sw}, 32'h0);
        step(1);
        chk("t1_e1_front", {28'd0, front_sw}, 32'h5);
        chk("t1_e1_blank", {28'd0, blank}, 32'h5);
        chk("t1_e1_busy", {31'd0, busy}, 32'h1);
        step(1);
        chk("t1_e2_blank", {28'd0, blank}, 32'h0);
        chk("t1_e2_busy", {31'd0, busy}, 32'h0);
        chk("t1_e2_front", {28'd0, front_sw}, 32'h5);

        // Request equal to current mapping is a no-op
        wr(8'd0, 32'h0000_0005);
        chk("t5_busy0", {31'd0, busy}, 32'h0);
        chk("t5_blank0", {28'd0, blank}, 32'h0);
        step(1);
        chk("t5_busy1", {31'd0, busy}, 32'h0);
`ifdef FRONTEND_SW_STATS_EN
        chk("t5_sw_count", {16'd0, sw_count}, 32'd1);
`endif

        // Busy channel, tmo=0: waits until run drops
        do_reset();
        run_in = 4'b0001;
        wr(8'd0, 32'h0000_0001);
        step(49);
        chk("t2_wait_busy", {31'd0, busy}, 32'h1);
        chk("t2_wait_front", {28'd0, front_sw}, 32'h0);
        @(negedge clk);
        run_in = 4'b0000;
        step(1);
        chk("t2_sw_front", {28'd0, front_sw}, 32'h1);
        chk("t2_sw_blank", {28'd0, blank}, 32'h1);
        chk("t2_tmo_flag", {31'd0, timeout_flag}, 32'h0);

        // Timeout after 10 wait cycles
        do_reset();
        run_in = 4'b0010;
        wr(8'd1, 32'h000A_0000);
        wr(8'd0, 32'h0000_0002);
        step(9);
        chk("t3_e9_front", {28'd0, front_sw}, 32'h0);
        chk("t3_e9_busy", {31'd0, busy}, 32'h1);
        step(1);
        chk("t3_e10_front", {28'd0, front_sw}, 32'h2);
        chk("t3_e10_flag", {31'd0, timeout_flag}, 32'h1);
        step(1);
        chk("t3_e11_busy", {31'd0, busy}, 32'h0);
        chk("t3_flag_sticky", {31'd0, timeout_flag}, 32'h1);
        run_in = 4'b0000;
        wr(8'd0, 32'h0000_0002);
        chk("t3_flag_clr", {31'd0, timeout_flag}, 32'h0);

        // Forced switch ignores busy channels
        do_reset();
        run_in = 4'b1111;
        wr(8'd0, 32'h8000_0006);
        step(1);
        chk("force_front", {28'd0, front_sw}, 32'h6);
        chk("force_flag", {31'd0, timeout_flag}, 32'h0);
        run_in = 4'b0000;

        // Rewrite in WAIT reloads timeout and chg
        do_reset();
        run_in = 4'b0001;
        wr(8'd1, 32'h0004_0000);
        wr(8'd0, 32'h0000_0001);
        step(2);
        wr(8'd0, 32'h0000_0003);
        step(1);
        chk("rw_e4_front", {28'd0, front_sw}, 32'h0);
        chk("rw_e4_busy", {31'd0, busy}, 32'h1);
        step(3);
        chk("rw_e7_front", {28'd0, front_sw}, 32'h3);
        chk("rw_e7_flag", {31'd0, timeout_flag}, 32'h1);
        run_in = 4'b0000;

        // settle=5 with a pending write during SETTLE
        do_reset();
        wr(8'd1, 32'h0000_0005);
        wr(8'd0, 32'h0000_0008);
        step(1);
        chk("t4_e1_front", {28'd0, front_sw}, 32'h8);
        chk("t4_e1_blank", {28'd0, blank}, 32'h8);
        step(1);
        wr(8'd0, 32'h0000_0000);
        step(3);
        chk("t4_e6_blank", {28'd0, blank}, 32'h8);
        chk("t4_e6_busy", {31'd0, busy}, 32'h1);
        step(1);
        chk("t4_e7_blank", {28'd0, blank}, 32'h0);
        chk("t4_e7_busy", {31'd0, busy}, 32'h0);
        chk("t4_e7_front", {28'd0, front_sw}, 32'h8);
        step(1);
        chk("t4_e8_busy", {31'd0, busy}, 32'h1);
        step(1);
        chk("t4_e9_front", {28'd0, front_sw}, 32'h0);
        chk("t4_e9_blank", {28'd0, blank}, 32'h8);
        step(5);
        chk("t4_e14_blank", {28'd0, blank}, 32'h8);
        step(1);
        chk("t4_e15_blank", {28'd0, blank}, 32'h0);
        chk("t4_e15_busy", {31'd0, busy}, 32'h0);

        // Asynchronous reset during SETTLE
        do_reset();
        wr(8'd1, 32'h0000_0005);
        wr(8'd0, 32'h0000_000F);
        step(3);
        chk("t6_pre_blank", {28'd0, blank}, 32'hF);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_front", {28'd0, front_sw}, 32'h0);
        chk("t6_async_blank", {28'd0, blank}, 32'h0);
        chk("t6_async_busy", {31'd0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wr(8'd0, 32'h0000_0003);
        step(1);
        chk("t6_after_front", {28'd0, front_sw}, 32'h3);
        chk("t6_after_blank", {28'd0, blank}, 32'h3);
        step(1);
        chk("t6_after_idle", {31'd0, busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
